// File: rtl/axis_sim_pkt_gen.sv
// AXI4-Stream packet stimulus generator: emits fixed-length packets with a payload that a
// checker can predict from packet index and length, plus NetFPGA SUME style TUSER metadata.
module axis_sim_pkt_gen #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  SRC_PORT             = 8'h01,
    parameter int unsigned MIN_PKT_LEN          = 60
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic [15:0]                          pkt_len,
    input  logic [15:0]                          num_pkts,
    input  logic [7:0]                           ifg,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 busy,
    output logic                                 done,
    output logic [15:0]                          pkt_cnt
);

    localparam int unsigned BeatBytes = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned BeatShift = $clog2(BeatBytes);
    localparam int unsigned BeatW     = 17 - BeatShift;

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        num_q, num_d;
    logic [7:0]         ifg_q, ifg_d;
    logic [7:0]         gap_q, gap_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [15:0]        pkt_q, pkt_d;
    logic               stop_q, stop_d;

    logic [15:0]        len_clamp;
    logic [16:0]        beats_m1;
    logic               is_last;
    logic               sending;
    logic               accept;
    logic [15:0]        pkt_inc;
    logic [16:0]        off_base;

    assign len_clamp = (pkt_len < 16'(MIN_PKT_LEN)) ? 16'(MIN_PKT_LEN) : pkt_len;
    // 17-bit ceil division so a 65535-byte packet still yields 2048 beats
    assign beats_m1  = (({1'b0, len_q} + 17'(BeatBytes - 1)) >> BeatShift) - 17'd1;
    assign is_last   = (beats_m1 == 17'(beat_q));
    assign sending   = (state_q == StSend);
    assign accept    = sending & m_axis_tready;
    assign pkt_inc   = pkt_q + 16'd1;
    assign off_base  = {beat_q, {BeatShift{1'b0}}};

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= StIdle;
            len_q   <= '0;
            num_q   <= '0;
            ifg_q   <= '0;
            gap_q   <= '0;
            beat_q  <= '0;
            pkt_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            ifg_q   <= ifg_d;
            gap_q   <= gap_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        ifg_d   = ifg_q;
        gap_d   = gap_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        stop_d  = stop_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    len_d   = len_clamp;
                    num_d   = num_pkts;
                    ifg_d   = ifg;
                    beat_d  = '0;
                    pkt_d   = '0;
                    stop_d  = 1'b0;
                    state_d = StSend;
                end
            end
            StSend: begin
                // stop is remembered so the packet in flight always completes
                stop_d = stop_q | stop;
                if (accept) begin
                    if (is_last) begin
                        beat_d = '0;
                        pkt_d  = pkt_inc;
                        if (((num_q != 16'd0) && (pkt_inc == num_q)) || stop_q || stop) begin
                            state_d = StDone;
                        end else if (ifg_q != 8'd0) begin
                            gap_d   = ifg_q - 8'd1;
                            state_d = StGap;
                        end else begin
                            state_d = StSend;
                        end
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StGap: begin
                stop_d = stop_q | stop;
                if (gap_q == 8'd0) begin
                    state_d = (stop_q || stop) ? StDone : StSend;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < int'(BeatBytes); i++) begin
            logic [16:0] off;
            off = off_base + 17'(i);
            if (sending && (off < {1'b0, len_q})) begin
                m_axis_tdata[8*i +: 8] = pkt_q[7:0] + off[7:0];
            end
        end
    end

    always_comb begin
        m_axis_tkeep = '0;
        m_axis_tuser = '0;
        if (sending) begin
            m_axis_tkeep = '1;
            if (is_last && (len_q[BeatShift-1:0] != '0)) begin
                m_axis_tkeep = ~({(BeatBytes){1'b1}} << len_q[BeatShift-1:0]);
            end
            m_axis_tuser[15:0]  = len_q;
            m_axis_tuser[23:16] = SRC_PORT;
        end
    end

    assign m_axis_tvalid = sending;
    assign m_axis_tlast  = sending & is_last;
    assign busy          = (state_q == StSend) || (state_q == StGap);
    assign done          = (state_q == StDone);
    assign pkt_cnt       = pkt_q;

endmodule

// File: tb/tb_axis_sim_pkt_gen.sv
// Directed bench for axis_sim_pkt_gen: checks every beat against the payload formula.
module tb_axis_sim_pkt_gen;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic [15:0]  pkt_len;
    logic [15:0]  num_pkts;
    logic [7:0]   ifg;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic         busy;
    logic         done;
    logic [15:0]  pkt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    axis_sim_pkt_gen dut (
        .axis_aclk     (clk),
        .axis_resetn   (rst_n),
        .start         (start),
        .stop          (stop),
        .pkt_len       (pkt_len),
        .num_pkts      (num_pkts),
        .ifg           (ifg),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tuser  (tuser),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .done          (done),
        .pkt_cnt       (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] exp_data(input int p, input int b, input int len);
        logic [255:0] d;
        d = '0;
        for (int i = 0; i < 32; i++) begin
            if (32 * b + i < len) d[8*i +: 8] = 8'((p + 32 * b + i) % 256);
        end
        return d;
    endfunction

    function automatic logic [31:0] exp_keep(input int b, input int len);
        int nb;
        nb = (len + 31) / 32;
        if (b == nb - 1 && (len % 32) != 0) return 32'((64'd1 << (len % 32)) - 64'd1);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [127:0] exp_user(input int len);
        logic [127:0] u;
        u = '0;
        u[15:0]  = 16'(len);
        u[23:16] = 8'h01;
        return u;
    endfunction

    task automatic start_run(input int len, input int n, input int gap);
        pkt_len  = 16'(len);
        num_pkts = 16'(n);
        ifg      = 8'(gap);
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("first_valid_latency", tvalid, 1'b1);
        chk("busy_after_start", busy, 1'b1);
        chk("done_cleared", done, 1'b0);
    endtask

    // Receives one packet; idle counts tvalid-low cycles seen before the first beat.
    task automatic recv_pkt(input int p, input int len, input bit rnd, input int stop_beat,
                            input bit start_last, output int idle, output logic [31:0] lkeep,
                            output logic [255:0] first);
        int nb;
        int b;
        int guard;
        nb    = (len + 31) / 32;
        b     = 0;
        guard = 0;
        idle  = 0;
        lkeep = '0;
        first = '0;
        while (tvalid !== 1'b1 && idle < 300) begin
            step();
            idle++;
        end
        chk($sformatf("pkt%0d_appears", p), tvalid, 1'b1);
        while (b < nb && guard < 3000) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stop   = (b == stop_beat);
            start  = start_last && (b == nb - 1);
            chk($sformatf("p%0d_b%0d_tvalid", p, b), tvalid, 1'b1);
            chk($sformatf("p%0d_b%0d_tdata", p, b), tdata, exp_data(p, b, len));
            chk($sformatf("p%0d_b%0d_tkeep", p, b), tkeep, exp_keep(b, len));
            chk($sformatf("p%0d_b%0d_tlast", p, b), tlast, (b == nb - 1));
            chk($sformatf("p%0d_b%0d_tuser", p, b), tuser, exp_user(len));
            if (b == 0) first = tdata;
            if (b == nb - 1) lkeep = tkeep;
            step();
            if (tready) b++;
            guard++;
        end
        tready = 1'b1;
        stop   = 1'b0;
        start  = 1'b0;
        chk($sformatf("p%0d_all_beats", p), b, nb);
    endtask

    task automatic chk_done(input string tag, input int cnt);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_tvalid"}, tvalid, 1'b0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 16'(cnt));
    endtask

    initial begin
        int           idle;
        logic [31:0]  lk;
        logic [255:0] fd;
        logic [255:0] beat0_ref;

        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        pkt_len  = '0;
        num_pkts = '0;
        ifg      = '0;
        tready   = 1'b1;
        #12;
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, 16'd0);
        chk("rst_tdata", tdata, 256'd0);
        chk("rst_tkeep", tkeep, 32'd0);
        chk("rst_tuser", tuser, 128'd0);
        rst_n = 1'b1;
        step();

        // stop while idle must be ignored
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("idle_stop_ignored", busy, 1'b0);

        // single 64-byte packet; a start coinciding with the final tlast is ignored
        start_run(64, 1, 0);
        chk("t1_tuser", tuser, {104'd0, 8'h01, 16'd64});
        recv_pkt(0, 64, 1'b0, -1, 1'b1, idle, lk, fd);
        beat0_ref = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
        chk("t1_beat0_bytes", fd, beat0_ref);
        chk("t1_last_keep", lk, 32'hFFFF_FFFF);
        chk_done("t1", 1);
        step();
        chk("t1_done_held", done, 1'b1);

        // 65-byte packets with a 4-cycle gap
        start_run(65, 3, 4);
        recv_pkt(0, 65, 1'b0, -1, 1'b0, idle, lk, fd);
        chk("t2_p0_last_keep", lk, 32'h0000_0001);
        recv_pkt(1, 65, 1'b0, -1, 1'b0, idle, lk, fd);
        chk("t2_gap_p1", idle, 4);
        recv_pkt(2, 65, 1'b0, -1, 1'b0, idle, lk, fd);
        chk("t2_gap_p2", idle, 4);
        chk("t2_p2_byte0", fd[7:0], 8'h02);
        chk_done("t2", 3);

        // short length clamped up to 60 bytes
        start_run(10, 1, 0);
        chk("t3_tuser_len", tuser[15:0], 16'd60);
        recv_pkt(0, 60, 1'b0, -1, 1'b0, idle, lk, fd);
        chk("t3_last_keep", lk, 32'h0FFF_FFFF);
        chk_done("t3", 1);

        // random backpressure, back-to-back packets
        start_run(100, 5, 0);
        for (int p = 0; p < 5; p++) begin
            recv_pkt(p, 100, 1'b1, -1, 1'b0, idle, lk, fd);
            chk($sformatf("t4_p%0d_no_gap", p), idle, 0);
        end
        chk_done("t4", 5);

        // unbounded run stopped during beat 1 of packet 7
        start_run(96, 0, 1);
        for (int p = 0; p < 8; p++) begin
            recv_pkt(p, 96, 1'b0, (p == 7) ? 1 : -1, 1'b0, idle, lk, fd);
            if (p > 0) chk($sformatf("t5_p%0d_gap", p), idle, 1);
        end
        chk_done("t5", 8);

        // asynchronous reset mid-packet, then a fresh run starts at packet 0
        start_run(128, 2, 0);
        step();
        chk("t6_mid_tvalid", tvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_tvalid", tvalid, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_pkt_cnt", pkt_cnt, 16'd0);
        chk("t6_async_tdata", tdata, 256'd0);
        #3;
        rst_n = 1'b1;
        step();
        chk("t6_idle_after_reset", tvalid, 1'b0);
        start_run(64, 1, 0);
        recv_pkt(0, 64, 1'b0, -1, 1'b0, idle, lk, fd);
        chk("t6_restart_byte0", fd[7:0], 8'h00);
        chk_done("t6", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_sim_pkt_gen.md
Name: axis_sim_pkt_gen

Overview:
- AXI4-Stream packet stimulus generator inside the emulation wrapper; drives the datapath input under test.
- Emits a programmed number of packets of fixed length with a deterministic payload.
- Uses NetFPGA SUME metadata: 256-bit TDATA and 128-bit TUSER carrying length and source port.
- A downstream checker can predict every byte from packet index and length alone.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, TDATA width in bits; TKEEP is width/8 bits.
C_M_AXIS_TUSER_WIDTH, 128, TUSER width in bits.
SRC_PORT, 8'h01, one-hot source port value placed in TUSER[23:16].
MIN_PKT_LEN, 60, minimum byte length; smaller programmed lengths are clamped up to this value.

Ports:
axis_aclk  in  1  single clock for all logic.
axis_resetn  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; samples pkt_len, num_pkts and ifg, then begins generation; ignored while busy.
stop  in  1  level; the current packet completes, then the block enters DONE.
pkt_len  in  16  packet length in bytes.
num_pkts  in  16  packets to send; 0 = unbounded until stop.
ifg  in  8  idle cycles inserted between packets.
m_axis_tdata  out  256  payload.
m_axis_tkeep  out  32  byte enables.
m_axis_tuser  out  128  metadata.
m_axis_tvalid  out  1  AXIS valid.
m_axis_tready  in  1  AXIS ready.
m_axis_tlast  out  1  last beat of packet.
busy  out  1  high from the cycle after an accepted start until DONE is entered.
done  out  1  level; high in DONE, cleared by the next accepted start.
pkt_cnt  out  16  packets fully sent; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, takes effect immediately mid-packet): state IDLE; tvalid, tlast, busy, done = 0; pkt_cnt, tdata, tkeep, tuser = 0.
- Captured length L = max(pkt_len, MIN_PKT_LEN), latched at start. Beats B = ceil(L/32) using a 17-bit intermediate, so L = 65535 gives B = 2048.
- State IDLE: on start, latch L, num_pkts and ifg; clear pkt_cnt and done; go to SEND with beat index 0 and packet index p = 0.
- State SEND:
  - tvalid = 1.
  - Beat b, byte i (i = 0..31, byte 0 at tdata[7:0]) = (p[7:0] + 32*b + i) mod 256 when 32*b + i < L; otherwise 0.
  - tkeep = all ones except on the last beat, where it has (L mod 32) low bits set, or all ones if L mod 32 = 0.
  - tlast = 1 only on beat B-1.
  - tuser[15:0] = L, tuser[23:16] = SRC_PORT, all other bits 0; tuser is held on every beat of the packet.
  - A beat advances only on tvalid & tready. While tready = 0, tdata, tkeep, tlast and tuser hold stable.
- On an accepted tlast beat: pkt_cnt increments and p increments. The next state is chosen as follows:
  - Go to DONE if num_pkts != 0 and the updated p equals num_pkts, or if stop is high in that cycle.
  - Otherwise go to GAP if ifg != 0.
  - Otherwise go to SEND beat 0 on the next cycle, giving back-to-back packets with no idle cycle.
- State GAP: tvalid = 0 for exactly ifg cycles, then SEND. If stop is seen during GAP, go to DONE at the end of the gap instead of sending.
- State DONE: tvalid = 0, busy = 0, done = 1. A start pulse here behaves as in IDLE.
- stop asserted mid-packet never truncates the packet: the remaining beats are sent, then DONE. stop asserted in IDLE is ignored.
- A start that coincides with the final tlast acceptance is ignored.
- Latency: first tvalid appears on the cycle after the start pulse.

Test Plan:
- Reset released; start with pkt_len=64, num_pkts=1, ifg=0, tready=1 -> 2 beats. Beat0 bytes 0x00..0x1F, beat1 bytes 0x20..0x3F with tkeep=32'hFFFFFFFF and tlast=1. tuser[15:0]=64, tuser[23:16]=SRC_PORT. Then pkt_cnt=1, done=1.
- pkt_len=65, num_pkts=3, ifg=4 -> 3 beats per packet, last-beat tkeep=32'h00000001. Packet 2 byte0 = 0x02. Exactly 4 idle cycles between each tlast and the next first beat. Final pkt_cnt=3.
- pkt_len=10 -> clamped to L=60: tuser[15:0]=60, 2 beats, last-beat tkeep=32'h0FFFFFFF.
- Random tready toggling (50%) with pkt_len=100, num_pkts=5 -> outputs stable while stalled. Checker sees 5 packets with byte values predicted by the formula.
- num_pkts=0, pulse stop during beat 1 of packet 7 -> packet 7 completes fully, done=1, pkt_cnt=8.
- Drop axis_resetn mid-packet -> tvalid=0 with no clock edge. After release, start produces packet index 0 again.
